// File: rtl/caddsub_pkg.sv
// caddsub_pkg: shared types and constants for the pipelined complex
// add/subtract/butterfly unit.
//   op_t        operation code carried with each operand pair
//   NUM_COMP    number of scalar component lanes in the compute stage
//   smax/smin   saturation clamp values for a given component width
package caddsub_pkg;

    // Code 3 is reserved and is executed as OP_ADD.
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_BFLY = 2'd2
    } op_t;

    // Component lanes: 0 = S.re, 1 = S.im, 2 = D.re, 3 = D.im
    localparam int NUM_COMP = 4;

    // Largest positive two's-complement value of width w.
    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value of width w.
    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/caddsub_pipe_addsubsat.sv
// addsubsat: one signed scalar add/subtract with overflow detect and
// optional saturation. Purely combinational.
//   a_i, b_i   two's-complement operands
//   sub_i      1 = a - b, 0 = a + b
//   s_o        result (clamped when SAT != 0, wrapped otherwise)
//   ovf_o      result did not fit in DATA_W bits
module addsubsat
    import caddsub_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SAT    = 1
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] s_o,
    output logic              ovf_o
);

    localparam logic [DATA_W-1:0] SMAX_C = DATA_W'(smax(DATA_W));
    localparam logic [DATA_W-1:0] SMIN_C = DATA_W'(smin(DATA_W));

    logic [DATA_W:0] a_x;
    logic [DATA_W:0] b_x;
    logic [DATA_W:0] r_x;

    always_comb begin
        // One guard bit is enough: the exact result of a +/- b always fits.
        a_x   = {a_i[DATA_W-1], a_i};
        b_x   = {b_i[DATA_W-1], b_i};
        r_x   = sub_i ? (a_x - b_x) : (a_x + b_x);
        ovf_o = r_x[DATA_W] ^ r_x[DATA_W-1];
        // The guard bit carries the true sign, so it picks the clamp direction.
        if ((SAT != 0) && ovf_o) begin
            s_o = r_x[DATA_W] ? SMIN_C : SMAX_C;
        end else begin
            s_o = r_x[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/caddsub_pipe.sv
// caddsub_pipe: two-stage pipelined complex add / subtract / butterfly.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operand handshake (in_ready depends on out_ready only)
//   in_op                      caddsub_pkg::op_t (3 behaves as OP_ADD)
//   a_re,a_im,b_re,b_im        complex operands A and B
//   out_valid/out_ready        result handshake
//   s_re,s_im                  A+B (ADD, BFLY) or A-B (SUB)
//   d_re,d_im                  A-B in BFLY, 0 otherwise
//   ovf                        overflow in any live component of the current result
//   ovf_sticky, ovf_clr        sticky OR of ovf over accepted results; clear (set wins)
module caddsub_pipe #(
    parameter int DATA_W = 32,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] s_re,
    output logic [DATA_W-1:0] s_im,
    output logic [DATA_W-1:0] d_re,
    output logic [DATA_W-1:0] d_im,
    output logic              ovf,
    output logic              ovf_sticky,
    input  logic              ovf_clr
);

    import caddsub_pkg::*;

    // Stage 1: captured operands ([0] = re, [1] = im) and op
    logic                        v1_q, v1_d;
    logic [1:0]                  op1_q, op1_d;
    logic [1:0][DATA_W-1:0]      a1_q, a1_d;
    logic [1:0][DATA_W-1:0]      b1_q, b1_d;

    // Stage 2: registered results, lane order S.re, S.im, D.re, D.im
    logic                        vout_q, vout_d;
    logic [NUM_COMP-1:0][DATA_W-1:0] res_q, res_d;
    logic                        ovf_q, ovf_d;
    logic                        sticky_q, sticky_d;

    logic                        en1, en2;
    logic                        is_sub, is_bfly;
    logic [NUM_COMP-1:0][DATA_W-1:0] cmp_s;
    logic [NUM_COMP-1:0]         cmp_ovf;

    // A stage may advance when the slot after it is empty or draining.
    assign en2      = !vout_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // Reserved code 3 matches neither test, so it falls through to ADD.
    assign is_sub  = (op1_q == OP_SUB);
    assign is_bfly = (op1_q == OP_BFLY);

    // Lanes 0/1 produce S (sub only for OP_SUB); lanes 2/3 always produce A-B
    // and are masked below unless the op is a butterfly.
    for (genvar k = 0; k < NUM_COMP; k++) begin : g_comp
        addsubsat #(
            .DATA_W (DATA_W),
            .SAT    (SAT)
        ) u_as (
            .a_i   (a1_q[k % 2]),
            .b_i   (b1_q[k % 2]),
            .sub_i ((k < 2) ? is_sub : 1'b1),
            .s_o   (cmp_s[k]),
            .ovf_o (cmp_ovf[k])
        );
    end

    always_comb begin
        v1_d  = v1_q;
        op1_d = op1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        if (en1) begin
            v1_d = in_valid;
            if (in_valid) begin
                op1_d = in_op;
                a1_d  = {a_im, a_re};
                b1_d  = {b_im, b_re};
            end
        end
    end

    always_comb begin
        vout_d = vout_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        if (en2) begin
            // Slot empties to zeros rather than keeping the last result.
            vout_d = v1_q;
            res_d  = '0;
            ovf_d  = 1'b0;
            if (v1_q) begin
                res_d[0] = cmp_s[0];
                res_d[1] = cmp_s[1];
                if (is_bfly) begin
                    res_d[2] = cmp_s[2];
                    res_d[3] = cmp_s[3];
                end
                ovf_d = cmp_ovf[0] | cmp_ovf[1] | (is_bfly & (cmp_ovf[2] | cmp_ovf[3]));
            end
        end
    end

    // Set takes priority over a simultaneous clear.
    always_comb begin
        sticky_d = (sticky_q & ~ovf_clr) | (vout_q & out_ready & ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            op1_q    <= 2'd0;
            a1_q     <= '0;
            b1_q     <= '0;
            vout_q   <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            op1_q    <= op1_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            vout_q   <= vout_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = vout_q;
    assign s_re       = res_q[0];
    assign s_im       = res_q[1];
    assign d_re       = res_q[2];
    assign d_im       = res_q[3];
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_caddsub_pipe.sv
// Bench for caddsub_pipe at DATA_W=8: a saturating and a wrapping instance
// share one input stream. Fixed vectors, hand sequences for sticky,
// backpressure and mid-stream reset, then a randomized stream checked
// against an integer-arithmetic reference model through a scoreboard.
module tb_caddsub_pipe;

    localparam int W    = 8;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int MODV = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready, ovf_clr;
    logic [1:0]   in_op;
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic         in_ready, out_valid, ovf, ovf_sticky;
    logic [W-1:0] s_re, s_im, d_re, d_im;
    logic         w_in_ready, w_out_valid, w_ovf, w_ovf_sticky;
    logic [W-1:0] w_s_re, w_s_im, w_d_re, w_d_im;

    always #5 clk = ~clk;

    caddsub_pipe #(.DATA_W(W), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .s_re(s_re), .s_im(s_im), .d_re(d_re), .d_im(d_im),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    caddsub_pipe #(.DATA_W(W), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .s_re(w_s_re), .s_im(w_s_im), .d_re(w_d_re), .d_im(w_d_im),
        .ovf(w_ovf), .ovf_sticky(w_ovf_sticky), .ovf_clr(ovf_clr)
    );

    typedef struct {
        int s_re, s_im, d_re, d_im;
        bit ovf;
    } res_t;

    typedef struct {
        int op, ar, ai, br, bi;
        int sr, si, dr, di;
        bit ovf;
    } vec_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    res_t q_sat[$];
    res_t q_wrap[$];
    int   n_out;

    // ---------------- reference model ----------------
    function automatic void comp(input int a, input int b, input bit sub, input bit sat,
                                 output int r, output bit o);
        int x;
        x = sub ? a - b : a + b;
        o = (x > MAXV) || (x < MINV);
        if (!o)       r = x;
        else if (sat) r = (x > 0) ? MAXV : MINV;
        else          r = (x > 0) ? x - MODV : x + MODV;
    endfunction

    function automatic res_t model(input int op, input int ar, input int ai,
                                   input int br, input int bi, input bit sat);
        res_t r;
        bit   o0, o1, o2, o3;
        bit   sub, bf;
        sub = (op == 1);
        bf  = (op == 2);
        comp(ar, br, sub, sat, r.s_re, o0);
        comp(ai, bi, sub, sat, r.s_im, o1);
        comp(ar, br, 1'b1, sat, r.d_re, o2);
        comp(ai, bi, 1'b1, sat, r.d_im, o3);
        if (!bf) begin
            r.d_re = 0; r.d_im = 0; o2 = 1'b0; o3 = 1'b0;
        end
        r.ovf = o0 | o1 | o2 | o3;
        return r;
    endfunction

    // ---------------- helpers ----------------
    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic res_t got_sat();
        res_t r;
        r.s_re = sx(s_re); r.s_im = sx(s_im); r.d_re = sx(d_re); r.d_im = sx(d_im);
        r.ovf  = ovf;
        return r;
    endfunction

    function automatic res_t got_wrap();
        res_t r;
        r.s_re = sx(w_s_re); r.s_im = sx(w_s_im); r.d_re = sx(w_d_re); r.d_im = sx(w_d_im);
        r.ovf  = w_ovf;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk_res(input string name, input res_t got, input res_t exp);
        chk({name, " s_re"}, got.s_re, exp.s_re);
        chk({name, " s_im"}, got.s_im, exp.s_im);
        chk({name, " d_re"}, got.d_re, exp.d_re);
        chk({name, " d_im"}, got.d_im, exp.d_im);
        chk({name, " ovf"},  int'(got.ovf), int'(exp.ovf));
    endtask

    task automatic drive(input int op, input int ar, input int ai, input int br, input int bi);
        in_op = 2'(op);
        a_re  = W'(ar); a_im = W'(ai); b_re = W'(br); b_im = W'(bi);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with scoreboard bookkeeping: handshakes are sampled before the
    // edge, results popped and compared, held outputs checked for stability.
    task automatic step(output bit ihs);
        bit   ohs, hold;
        res_t cs, cw, es, ew;
        @(negedge clk);
        ihs  = in_valid && in_ready;
        ohs  = out_valid && out_ready;
        hold = out_valid && !out_ready;
        cs   = got_sat();
        cw   = got_wrap();
        if (ihs) begin
            q_sat.push_back(model(int'(in_op), sx(a_re), sx(a_im), sx(b_re), sx(b_im), 1'b1));
            q_wrap.push_back(model(int'(in_op), sx(a_re), sx(a_im), sx(b_re), sx(b_im), 1'b0));
        end
        @(posedge clk);
        #1;
        if (ohs) begin
            n_out++;
            if (q_sat.size() == 0) begin
                chk("unexpected result", 1, 0);
            end else begin
                es = q_sat.pop_front();
                ew = q_wrap.pop_front();
                chk_res("stream sat", cs, es);
                chk_res("stream wrap", cw, ew);
            end
        end
        if (hold) begin
            chk("hold out_valid", int'(out_valid), 1);
            chk_res("hold stable", got_sat(), cs);
        end
    endtask

    vec_t tbl[7];
    res_t exp_r;
    bit   acc;
    bit   saw_stall;
    int   sent, cyc;

    initial begin
        // Hand-derived expectations for the saturating instance.
        tbl[0] = '{2,   10,   -3,   4,    5,   14,    2,    6,   -8, 1'b0};
        tbl[1] = '{0,  100, -100,  50,  -50,  127, -128,    0,    0, 1'b1};
        tbl[2] = '{1,    5,    5,   3,   -3,    2,    8,    0,    0, 1'b0};
        tbl[3] = '{3,    1,    2,   3,    4,    4,    6,    0,    0, 1'b0};
        tbl[4] = '{2, -128,  127,   1,    1, -127,  127, -128,  126, 1'b1};
        tbl[5] = '{1, -128,    0,   1, -128, -128,  127,    0,    0, 1'b1};
        tbl[6] = '{0,  127, -128,   0,   -1,  127, -128,    0,    0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(0, 100, 100, 100, 100);

        // ---- reset with in_valid held high ----
        repeat (3) tick();
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst ovf_sticky", int'(ovf_sticky), 0);
        chk("rst ovf", int'(ovf), 0);
        chk("rst s_re", sx(s_re), 0);
        chk("rst d_im", sx(d_im), 0);
        chk("rst wrap out_valid", int'(w_out_valid), 0);
        chk("rst wrap sticky", int'(w_ovf_sticky), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post-rst in_ready", int'(in_ready), 1);
        chk("post-rst wrap in_ready", int'(w_in_ready), 1);
        chk("post-rst out_valid", int'(out_valid), 0);

        // ---- table vectors, one at a time, exact latency ----
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d lat1 out_valid", i), int'(out_valid), 0);
            tick();
            chk($sformatf("vec%0d lat2 out_valid", i), int'(out_valid), 1);
            exp_r = '{tbl[i].sr, tbl[i].si, tbl[i].dr, tbl[i].di, tbl[i].ovf};
            chk_res($sformatf("vec%0d sat", i), got_sat(), exp_r);
            chk_res($sformatf("vec%0d wrap", i), got_wrap(),
                    model(tbl[i].op, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, 1'b0));
            if (i == 1) begin
                chk("wrap add s_re", sx(w_s_re), -106);
                chk("wrap add s_im", sx(w_s_im), 106);
            end
            tick();
            chk($sformatf("vec%0d drained", i), int'(out_valid), 0);
            if (tbl[i].ovf) chk($sformatf("vec%0d sticky", i), int'(ovf_sticky), 1);
        end

        // ---- sticky: set wins over clear, then clear alone ----
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sticky cleared", int'(ovf_sticky), 0);
        out_ready = 1'b0;
        drive(0, 100, 0, 50, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sticky ovf shown", int'(ovf), 1);
        chk("sticky not before hs", int'(ovf_sticky), 0);
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        chk("sticky set beats clr", int'(ovf_sticky), 1);
        tick();
        ovf_clr = 1'b0;
        chk("sticky clr alone", int'(ovf_sticky), 0);

        // ---- backpressure: 5 ADDs, out_ready low for cycles 3..6 ----
        q_sat.delete(); q_wrap.delete();
        n_out = 0; sent = 0; saw_stall = 1'b0; cyc = 0;
        drive(0, 10, 20, 1, 2);
        in_valid = 1'b1;
        while ((n_out < 5) && (cyc < 40)) begin
            out_ready = !((cyc >= 3) && (cyc <= 6));
            if (in_valid && !in_ready) saw_stall = 1'b1;
            step(acc);
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 5) drive(0, 10 + 10 * sent, 20 + 20 * sent, sent, -sent);
                else in_valid = 1'b0;
            end
        end
        chk("bp all results", n_out, 5);
        chk("bp in_ready dropped", int'(saw_stall), 1);
        chk("bp queue empty", q_sat.size(), 0);

        // ---- mid-stream reset with 2 in flight ----
        out_ready = 1'b0;
        drive(2, 1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        drive(0, 2, 2, 2, 2);
        tick();
        in_valid = 1'b0;
        chk("mid pre-rst in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst in_ready", int'(in_ready), 1);
        chk("mid rst s_re", sx(s_re), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid idle%0d out_valid", k), int'(out_valid), 0);
        end
        drive(2, 10, -3, 4, 5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid next out_valid", int'(out_valid), 1);
        exp_r = '{14, 2, 6, -8, 1'b0};
        chk_res("mid next", got_sat(), exp_r);
        tick();

        // ---- randomized stream with random backpressure ----
        q_sat.delete(); q_wrap.delete();
        n_out = 0;
        in_valid = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                drive(int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; (c < 20) && (q_sat.size() != 0); c++) step(acc);
        chk("rand drained", q_sat.size(), 0);
        chk("rand idle out_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
